hazard_unit: RTL and testbench

//  Decode-stage hazard detector that produces the stall into the ID/EX register.
//  - Keeps a 3-entry scoreboard (X, M, W) of in-flight destination registers.
//  - Compares decode-stage sources against the scoreboard and raises stall on a RAW hazard.
//  - Handles taken-branch flushes from X.
//  - Keeps a saturating count of stall cycles for performance runs.

---
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hazard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Decode/flush request and hazard response signals between the decode stage and hazard_unit.
// Pure wiring; no latency of its own.
// No backpressure: the producer of the decode fields is held by the stall output.
interface hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic             valid_d;
   logic [2:0]       Rs_d;
   logic [2:0]       Rt_d;
   logic             useRs_d;
   logic             useRt_d;
   logic [2:0]       Rd_d;
   logic             RegWrite_d;
   logic             MemRead_d;
   logic             flush_x;
   logic             stall;
   logic             kill_d;
   logic [1:0]       fwd_rs_x;
   logic [1:0]       fwd_rt_x;
   logic [CNT_W-1:0] stall_cnt;

   // Pipeline side: drives the decode fields and the X-stage flush.
   modport master (
      output valid_d, Rs_d, Rt_d, useRs_d, useRt_d, Rd_d, RegWrite_d, MemRead_d, flush_x,
      input  stall, kill_d, fwd_rs_x, fwd_rt_x, stall_cnt
   );

   // Hazard unit side.
   modport slave (
      input  valid_d, Rs_d, Rt_d, useRs_d, useRt_d, Rd_d, RegWrite_d, MemRead_d, flush_x,
      output stall, kill_d, fwd_rs_x, fwd_rt_x, stall_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Decode-stage RAW hazard detector with an X/M/W scoreboard, flush handling and a saturating stall counter.
// stall/kill_d/fwd are combinational from the current scoreboard; scoreboard and counter update each clock.
// Never backpressured itself; its stall output holds PC and IF/ID. Optional FORWARD_EN enables bypass selects.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst,     // asynchronous, active-low
   hazard_unit_if.slave hz
);

   typedef struct packed {
      logic       vld;
      logic       wr;
      logic       ld;
      logic [2:0] rd;
      logic [2:0] rs;
      logic       urs;
      logic [2:0] rt;
      logic       urt;
   } sb_entry_t;

   sb_entry_t        x_q, x_d;
   sb_entry_t        m_q, m_d;
   sb_entry_t        w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             haz_rs;
   logic             haz_rt;
   logic             stall_c;
   logic [1:0]       fwd_rs_c;
   logic [1:0]       fwd_rt_c;

   // An in-flight entry that will produce register s and is a stall source.
   // With bypassing only a load in X cannot be served in time.
   function automatic logic src_hit(input sb_entry_t e, input logic [2:0] s);
`ifdef FORWARD_EN
      return e.vld & e.wr & e.ld & (e.rd == s);
`else
      return e.vld & e.wr & (e.rd == s);
`endif
   endfunction

   // Compare decode sources against X (and M without bypassing); flush overrides stall.
   always_comb begin
      haz_rs = 1'b0;
      haz_rt = 1'b0;
`ifdef FORWARD_EN
      haz_rs = hz.useRs_d & src_hit(x_q, hz.Rs_d);
      haz_rt = hz.useRt_d & src_hit(x_q, hz.Rt_d);
`else
      haz_rs = hz.useRs_d & (src_hit(x_q, hz.Rs_d) | src_hit(m_q, hz.Rs_d));
      haz_rt = hz.useRt_d & (src_hit(x_q, hz.Rt_d) | src_hit(m_q, hz.Rt_d));
`endif
      stall_c = hz.valid_d & (haz_rs | haz_rt) & ~hz.flush_x;
   end

`ifdef FORWARD_EN
   // Bypass select for one X-stage source: non-load in M first, then anything in W.
   function automatic logic [1:0] fwd_sel(input logic [2:0] src, input logic use_src,
                                          input sb_entry_t m, input sb_entry_t w);
      if (use_src & m.vld & m.wr & ~m.ld & (m.rd == src)) begin
         return 2'b01;
      end else if (use_src & w.vld & w.wr & (w.rd == src)) begin
         return 2'b10;
      end
      return 2'b00;
   endfunction

   // Bypass selects for the instruction currently in X.
   always_comb begin
      fwd_rs_c = fwd_sel(x_q.rs, x_q.urs, m_q, w_q);
      fwd_rt_c = fwd_sel(x_q.rt, x_q.urt, m_q, w_q);
   end
`else
   // Full interlock: operands always come from the register file.
   always_comb begin
      fwd_rs_c = 2'b00;
      fwd_rt_c = 2'b00;
   end
`endif

   // Next scoreboard contents and saturating stall count.
   always_comb begin
      x_d = '0;
      if (hz.valid_d && !stall_c && !hz.flush_x) begin
         x_d.vld = 1'b1;
         x_d.wr  = hz.RegWrite_d;
         x_d.ld  = hz.MemRead_d;
         x_d.rd  = hz.Rd_d;
         x_d.rs  = hz.Rs_d;
         x_d.urs = hz.useRs_d;
         x_d.rt  = hz.Rt_d;
         x_d.urt = hz.useRt_d;
      end
      m_d   = x_q;
      w_d   = m_q;
      cnt_d = cnt_q;
      if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Scoreboard shifts every edge (downstream never stalls); reset clears it immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         x_q   <= x_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   // Not every scoreboard field is consumed in every build.
   logic unused_sb;
   assign unused_sb = ^{x_q, m_q, w_q};

   assign hz.stall     = stall_c;
   assign hz.kill_d    = hz.flush_x;
   assign hz.fwd_rs_x  = fwd_rs_c;
   assign hz.fwd_rt_x  = fwd_rt_c;
   assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: reset, RAW stalls, load-use, flush priority, counter saturation, reset mid-stall.
// Uses a narrow counter so saturation is reachable quickly.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_hazard_unit;

   localparam int CNT_W = 8;
`ifdef FORWARD_EN
   localparam int   CNT_T2  = 0;
   localparam int   CNT_T3  = 1;
   localparam logic PROD_LD = 1'b1;
`else
   localparam int   CNT_T2  = 2;
   localparam int   CNT_T3  = 4;
   localparam logic PROD_LD = 1'b0;
`endif

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   seen;

   hazard_unit_if #(.CNT_W(CNT_W)) hif ();

   hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [2:0] rs, input logic urs,
                      input logic [2:0] rt, input logic urt,
                      input logic [2:0] rd, input logic wr, input logic ld);
      hif.valid_d    = v;
      hif.Rs_d       = rs;
      hif.useRs_d    = urs;
      hif.Rt_d       = rt;
      hif.useRt_d    = urt;
      hif.Rd_d       = rd;
      hif.RegWrite_d = wr;
      hif.MemRead_d  = ld;
   endtask

   task automatic nop();
      drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      nop();
      tick();
      tick();
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      seen   = 0;
      rst    = 1'b1;
      hif.flush_x = 1'b0;
      // ADD r3, r1, r2 held in decode during reset
      drv(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
      #1 rst = 1'b0;
      #2;

      // 1. reset state
      chk("rst_stall", hif.stall, 0);
      chk("rst_kill", hif.kill_d, 0);
      chk("rst_cnt", hif.stall_cnt, 0);
      chk("rst_fwd_rs", hif.fwd_rs_x, 0);
      chk("rst_fwd_rt", hif.fwd_rt_x, 0);
      hif.flush_x = 1'b1;
      #1;
      chk("rst_kill_follows_flush", hif.kill_d, 1);
      hif.flush_x = 1'b0;
      tick();
      tick();
      chk("rst_held_stall", hif.stall, 0);
      chk("rst_held_cnt", hif.stall_cnt, 0);
      #2 rst = 1'b1;

      // 2. ADD r3 then ADD r4,r3,r1
      #1;
      chk("t2_first_no_stall", hif.stall, 0);
      tick();
      drv(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
      #1;
`ifdef FORWARD_EN
      chk("t2_fwd_no_stall", hif.stall, 0);
      tick();
      chk("t2_fwd_rs_m", hif.fwd_rs_x, 2'b01);
      chk("t2_fwd_rt_rf", hif.fwd_rt_x, 2'b00);
`else
      chk("t2_stall_c1", hif.stall, 1);
      tick();
      chk("t2_stall_c2", hif.stall, 1);
      tick();
      chk("t2_stall_c3", hif.stall, 0);
      tick();
      chk("t2_fwd_tied", hif.fwd_rs_x, 2'b00);
`endif
      chk("t2_cnt", hif.stall_cnt, CNT_T2);
      drain();

      // 3. LD r2 then ADD r5,r2,r2
      drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
      #1;
      chk("t3_ld_no_stall", hif.stall, 0);
      tick();
      drv(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
      #1;
      chk("t3_stall_c1", hif.stall, 1);
      tick();
`ifdef FORWARD_EN
      chk("t3_stall_c2", hif.stall, 0);
      tick();
      chk("t3_fwd_rs_w", hif.fwd_rs_x, 2'b10);
      chk("t3_fwd_rt_w", hif.fwd_rt_x, 2'b10);
`else
      chk("t3_stall_c2", hif.stall, 1);
      tick();
      chk("t3_stall_c3", hif.stall, 0);
      tick();
      chk("t3_fwd_rs_tied", hif.fwd_rs_x, 2'b00);
      chk("t3_fwd_rt_tied", hif.fwd_rt_x, 2'b00);
`endif
      chk("t3_cnt", hif.stall_cnt, CNT_T3);
      drain();

      // 4. LD r2 in X, dependent LD r5,(r2) in decode, flush in same cycle
      drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
      tick();
      drv(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);
      hif.flush_x = 1'b1;
      #1;
      chk("t4_flush_no_stall", hif.stall, 0);
      chk("t4_kill", hif.kill_d, 1);
      tick();
      hif.flush_x = 1'b0;
      // ADD r6, r5: would stall only if the squashed load had entered X
      drv(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
      #1;
      chk("t4_x_bubble", hif.stall, 0);
      chk("t4_kill_clear", hif.kill_d, 0);
      chk("t4_cnt_unchanged", hif.stall_cnt, CNT_T3);
      drain();

      // 5. self-dependent load keeps stalling; count must saturate
      drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
      for (int i = 0; i < 2000 && seen < (2 ** CNT_W) + 3; i++) begin
         #1;
         if (hif.stall === 1'b1) seen++;
         tick();
      end
      chk("t5_stalls_forced", seen, (2 ** CNT_W) + 3);
      chk("t5_cnt_sat", hif.stall_cnt, (2 ** CNT_W) - 1);
      tick();
      tick();
      tick();
      chk("t5_cnt_no_wrap", hif.stall_cnt, (2 ** CNT_W) - 1);
      drain();

      // 6. reset asserted inside a stall
      drv(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, PROD_LD);
      #1;
      chk("t6_prod_no_stall", hif.stall, 0);
      tick();
      drv(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
      #1;
      chk("t6_stall_c1", hif.stall, 1);
`ifndef FORWARD_EN
      tick();
      #1;
      chk("t6_stall_c2", hif.stall, 1);
`endif
      rst = 1'b0;
      #1;
      chk("t6_rst_stall_drop", hif.stall, 0);
      chk("t6_rst_cnt", hif.stall_cnt, 0);
      #1 rst = 1'b1;
      #1;
      chk("t6_release_no_stall", hif.stall, 0);
      tick();
      chk("t6_cnt_after", hif.stall_cnt, 0);
      nop();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
